// File: rtl/fp_mul_pipe.sv
// IEEE-754 single-precision multiplier: flush-to-zero, five rounding modes, overflow/underflow flags.
// Latency: edge N samples in_valid/operands, edge N+3 presents the result with out_valid=1.
// Backpressure: none; a new operation may be accepted on every cycle.
// Ports: clk, rst_n (async active-low); in_valid, r_mode[3:0], fp_X[31:0], fp_Y[31:0] in;
//        out_valid, fp_Z[31:0], ovrf, udrf out (outputs hold their value while out_valid=0).
module fp_mul_pipe #(
  parameter int          LATENCY = 3,
  parameter logic [31:0] QNAN    = 32'h7FC0_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [3:0]  r_mode,
  input  logic [31:0] fp_X,
  input  logic [31:0] fp_Y,
  output logic        out_valid,
  output logic [31:0] fp_Z,
  output logic        ovrf,
  output logic        udrf
);

  localparam logic [3:0] RM_RTZ = 4'd1;
  localparam logic [3:0] RM_RDN = 4'd2;
  localparam logic [3:0] RM_RUP = 4'd3;
  localparam logic [3:0] RM_RMM = 4'd4;

  // vld_q[0]: operand capture, [1]: S1, [2]: S2, [LATENCY]: output register
  logic [LATENCY:0] vld_q;

  // operand capture
  logic [31:0] x0_q, y0_q;
  logic [3:0]  rm0_q;

  // S1: classify, sign, exponent sum
  logic        sign1_d, spec1_d;
  logic [31:0] specz1_d;
  logic [9:0]  exp1_d;
  logic        x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
  logic        sign1_q, spec1_q;
  logic [31:0] specz1_q;
  logic [9:0]  exp1_q;
  logic [23:0] mx1_q, my1_q;
  logic [3:0]  rm1_q;

  // S2: significand product
  logic [47:0] prod2_d, prod2_q;
  logic        sign2_q, spec2_q;
  logic [31:0] specz2_q;
  logic [9:0]  exp2_q;
  logic [3:0]  rm2_q;

  // S3: normalize, round, pack
  logic [23:0] mant_n;
  logic        guard, sticky, inc;
  logic [9:0]  exp_n, exp_f;
  logic [24:0] mant_r;
  logic [22:0] frac;
  logic        ovf, udf;
  logic [30:0] ovf_mag;
  logic [31:0] z_d, z_q;
  logic        ovrf_d, udrf_d, ovrf_q, udrf_q;

  always_comb begin
    // exponent 0 covers subnormals too: they are flushed to zero here
    x_zero   = (x0_q[30:23] == 8'h00);
    y_zero   = (y0_q[30:23] == 8'h00);
    x_inf    = (x0_q[30:23] == 8'hFF) && (x0_q[22:0] == 23'd0);
    y_inf    = (y0_q[30:23] == 8'hFF) && (y0_q[22:0] == 23'd0);
    x_nan    = (x0_q[30:23] == 8'hFF) && (x0_q[22:0] != 23'd0);
    y_nan    = (y0_q[30:23] == 8'hFF) && (y0_q[22:0] != 23'd0);
    sign1_d  = x0_q[31] ^ y0_q[31];
    exp1_d   = {2'b00, x0_q[30:23]} + {2'b00, y0_q[30:23]} - 10'd127;
    spec1_d  = 1'b0;
    specz1_d = 32'd0;
    if (x_nan || y_nan || (x_inf && y_zero) || (y_inf && x_zero)) begin
      spec1_d  = 1'b1;
      specz1_d = QNAN;
    end else if (x_inf || y_inf) begin
      spec1_d  = 1'b1;
      specz1_d = {sign1_d, 8'hFF, 23'd0};
    end else if (x_zero || y_zero) begin
      spec1_d  = 1'b1;
      specz1_d = {sign1_d, 31'd0};
    end
  end

  assign prod2_d = {24'd0, mx1_q} * {24'd0, my1_q};

  always_comb begin
    if (prod2_q[47]) begin
      mant_n = prod2_q[47:24];
      guard  = prod2_q[23];
      sticky = |prod2_q[22:0];
      exp_n  = exp2_q + 10'd1;
    end else begin
      mant_n = prod2_q[46:23];
      guard  = prod2_q[22];
      sticky = |prod2_q[21:0];
      exp_n  = exp2_q;
    end
    case (rm2_q)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = (guard | sticky) & sign2_q;
      RM_RUP:  inc = (guard | sticky) & ~sign2_q;
      RM_RMM:  inc = guard;
      default: inc = guard & (sticky | mant_n[0]);
    endcase
    mant_r = {1'b0, mant_n} + {24'd0, inc};
    // carry-out of rounding leaves 1.000..0, so the fraction becomes all zeros
    frac   = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
    exp_f  = exp_n + {9'd0, mant_r[24]};
    ovf    = !spec2_q && ($signed(exp_f) >= 10'sd255);
    udf    = !spec2_q && ($signed(exp_f) <= 10'sd0);
    case (rm2_q)
      RM_RTZ:  ovf_mag = 31'h7F7F_FFFF;
      RM_RUP:  ovf_mag = sign2_q ? 31'h7F7F_FFFF : 31'h7F80_0000;
      RM_RDN:  ovf_mag = sign2_q ? 31'h7F80_0000 : 31'h7F7F_FFFF;
      default: ovf_mag = 31'h7F80_0000;
    endcase
    ovrf_d = ovf;
    udrf_d = udf;
    if (spec2_q)  z_d = specz2_q;
    else if (ovf) z_d = {sign2_q, ovf_mag};
    else if (udf) z_d = {sign2_q, 31'd0};
    else          z_d = {sign2_q, exp_f[7:0], frac};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q    <= '0;
      x0_q     <= '0;
      y0_q     <= '0;
      rm0_q    <= '0;
      sign1_q  <= 1'b0;
      spec1_q  <= 1'b0;
      specz1_q <= '0;
      exp1_q   <= '0;
      mx1_q    <= '0;
      my1_q    <= '0;
      rm1_q    <= '0;
      prod2_q  <= '0;
      sign2_q  <= 1'b0;
      spec2_q  <= 1'b0;
      specz2_q <= '0;
      exp2_q   <= '0;
      rm2_q    <= '0;
      z_q      <= '0;
      ovrf_q   <= 1'b0;
      udrf_q   <= 1'b0;
    end else begin
      vld_q <= {vld_q[LATENCY-1:0], in_valid};
      if (in_valid) begin
        x0_q  <= fp_X;
        y0_q  <= fp_Y;
        rm0_q <= r_mode;
      end
      if (vld_q[0]) begin
        sign1_q  <= sign1_d;
        spec1_q  <= spec1_d;
        specz1_q <= specz1_d;
        exp1_q   <= exp1_d;
        mx1_q    <= {1'b1, x0_q[22:0]};
        my1_q    <= {1'b1, y0_q[22:0]};
        rm1_q    <= rm0_q;
      end
      if (vld_q[1]) begin
        prod2_q  <= prod2_d;
        sign2_q  <= sign1_q;
        spec2_q  <= spec1_q;
        specz2_q <= specz1_q;
        exp2_q   <= exp1_q;
        rm2_q    <= rm1_q;
      end
      if (vld_q[2]) begin
        z_q    <= z_d;
        ovrf_q <= ovrf_d;
        udrf_q <= udrf_d;
      end
    end
  end

  assign out_valid = vld_q[LATENCY];
  assign fp_Z      = z_q;
  assign ovrf      = ovrf_q;
  assign udrf      = udrf_q;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Testbench for fp_mul_pipe: directed operations with a queue of expected results,
// checked whenever out_valid is seen; plus reset, hold, throughput and flush checks.
module tb_fp_mul_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [3:0]  r_mode;
  logic [31:0] fp_X, fp_Y;
  logic        out_valid;
  logic [31:0] fp_Z;
  logic        ovrf, udrf;

  typedef struct {
    logic [31:0] z;
    logic        ov;
    logic        ud;
    int          id;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] last_z      = 32'd0;

  always #5 clk = ~clk;

  fp_mul_pipe dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .r_mode   (r_mode),
    .fp_X     (fp_X),
    .fp_Y     (fp_Y),
    .out_valid(out_valid),
    .fp_Z     (fp_Z),
    .ovrf     (ovrf),
    .udrf     (udrf)
  );

  // scoreboard: every result the DUT emits must match the oldest pending expectation
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      assert (exp_q.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected_out_valid: got fp_Z=%h ovrf=%b udrf=%b, required no result", fp_Z, ovrf, udrf);
      end
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        assert ({fp_Z, ovrf, udrf} === {mon_e.z, mon_e.ov, mon_e.ud}) else begin
          miscompares++;
          $error("FAIL vec%0d: got fp_Z=%h ovrf=%b udrf=%b, required fp_Z=%h ovrf=%b udrf=%b",
                 mon_e.id, fp_Z, ovrf, udrf, mon_e.z, mon_e.ov, mon_e.ud);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: got %h, required %h", tag, got, want);
    end
  endtask

  // drive one operation for one cycle (entered and left at a falling edge)
  task automatic op(input logic [31:0] x, input logic [31:0] y, input logic [3:0] m,
                    input logic [31:0] z, input logic ov, input logic ud);
    exp_t e;
    in_valid = 1'b1;
    fp_X     = x;
    fp_Y     = y;
    r_mode   = m;
    e.z  = z;
    e.ov = ov;
    e.ud = ud;
    e.id = vectors;
    exp_q.push_back(e);
    last_z = z;
    vectors++;
    @(negedge clk);
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    assert (exp_q.size() == 0) else begin
      miscompares++;
      $error("FAIL drain_timeout: got %0d results outstanding, required 0", exp_q.size());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    r_mode   = 4'd0;
    fp_X     = 32'd0;
    fp_Y     = 32'd0;
    #12;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_fp_Z", fp_Z, 32'd0);
    chk("reset_ovrf", {31'd0, ovrf}, 32'd0);
    chk("reset_udrf", {31'd0, udrf}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // basic
    op(32'h3FC00000, 32'h40000000, 4'd0, 32'h40400000, 1'b0, 1'b0);
    // overflow in each mode / sign
    op(32'h7F000000, 32'h40000000, 4'd0, 32'h7F800000, 1'b1, 1'b0);
    op(32'h7F000000, 32'h40000000, 4'd1, 32'h7F7FFFFF, 1'b1, 1'b0);
    op(32'hFF000000, 32'h40000000, 4'd3, 32'hFF7FFFFF, 1'b1, 1'b0);
    op(32'h7F000000, 32'h40000000, 4'd3, 32'h7F800000, 1'b1, 1'b0);
    op(32'h7F000000, 32'h40000000, 4'd2, 32'h7F7FFFFF, 1'b1, 1'b0);
    op(32'hFF000000, 32'h40000000, 4'd2, 32'hFF800000, 1'b1, 1'b0);
    op(32'hFF000000, 32'h40000000, 4'd4, 32'hFF800000, 1'b1, 1'b0);
    // underflow at exponent 0, deep underflow, and smallest normal result
    op(32'h00800000, 32'h3F000000, 4'd0, 32'h00000000, 1'b0, 1'b1);
    op(32'h80800000, 32'h3F000000, 4'd0, 32'h80000000, 1'b0, 1'b1);
    op(32'h00800000, 32'h3F000000, 4'd3, 32'h00000000, 1'b0, 1'b1);
    op(32'h00800000, 32'h00800000, 4'd0, 32'h00000000, 1'b0, 1'b1);
    op(32'h00800000, 32'h3F800000, 4'd0, 32'h00800000, 1'b0, 1'b0);
    // 1+2^-22+2^-46: below half an ulp above 3F800002
    op(32'h3F800001, 32'h3F800001, 4'd0, 32'h3F800002, 1'b0, 1'b0);
    op(32'h3F800001, 32'h3F800001, 4'd1, 32'h3F800002, 1'b0, 1'b0);
    op(32'h3F800001, 32'h3F800001, 4'd2, 32'h3F800002, 1'b0, 1'b0);
    op(32'h3F800001, 32'h3F800001, 4'd3, 32'h3F800003, 1'b0, 1'b0);
    op(32'h3F800001, 32'h3F800001, 4'd4, 32'h3F800002, 1'b0, 1'b0);
    // exact tie with even lsb: RNE keeps, RMM rounds away; mode 7 acts as RNE
    op(32'h3F800003, 32'h3FC00000, 4'd0, 32'h3FC00004, 1'b0, 1'b0);
    op(32'h3F800003, 32'h3FC00000, 4'd4, 32'h3FC00005, 1'b0, 1'b0);
    op(32'h3F800003, 32'h3FC00000, 4'd7, 32'h3FC00004, 1'b0, 1'b0);
    // directed rounding on a negative result
    op(32'hBF800001, 32'h3F800001, 4'd2, 32'hBF800003, 1'b0, 1'b0);
    op(32'hBF800001, 32'h3F800001, 4'd3, 32'hBF800002, 1'b0, 1'b0);
    // rounding carry-out renormalizes to the next binade
    op(32'h3FFFFFFE, 32'h3F800001, 4'd0, 32'h40000000, 1'b0, 1'b0);
    op(32'h3FFFFFFE, 32'h3F800001, 4'd1, 32'h3FFFFFFF, 1'b0, 1'b0);
    // specials
    op(32'h7F800000, 32'h00000000, 4'd0, 32'h7FC00000, 1'b0, 1'b0);
    op(32'h7FC00001, 32'h3F800000, 4'd0, 32'h7FC00000, 1'b0, 1'b0);
    op(32'h80000000, 32'h3F800000, 4'd0, 32'h80000000, 1'b0, 1'b0);
    op(32'h00400000, 32'h40000000, 4'd0, 32'h00000000, 1'b0, 1'b0);
    op(32'hFF800000, 32'h40000000, 4'd0, 32'hFF800000, 1'b0, 1'b0);
    op(32'h7F800000, 32'hFF800000, 4'd1, 32'hFF800000, 1'b0, 1'b0);
    drain();

    // outputs hold the last result while idle
    repeat (3) @(negedge clk);
    chk("hold_out_valid", {31'd0, out_valid}, 32'd0);
    chk("hold_fp_Z", fp_Z, last_z);

    // four back-to-back operations -> four consecutive out_valid cycles
    op(32'h40000000, 32'h40000000, 4'd0, 32'h40800000, 1'b0, 1'b0);
    op(32'h40400000, 32'h40000000, 4'd0, 32'h40C00000, 1'b0, 1'b0);
    op(32'h3F800000, 32'h3F800000, 4'd0, 32'h3F800000, 1'b0, 1'b0);
    op(32'hC0000000, 32'h40400000, 4'd0, 32'hC0C00000, 1'b0, 1'b0);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("burst_valid_%0d", i), {31'd0, out_valid}, 32'd1);
      @(negedge clk);
    end
    chk("burst_end_valid", {31'd0, out_valid}, 32'd0);
    drain();

    // reset with two operations in flight
    op(32'h3FC00000, 32'h40000000, 4'd0, 32'h40400000, 1'b0, 1'b0);
    op(32'h40000000, 32'h40000000, 4'd0, 32'h40800000, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midreset_fp_Z", fp_Z, 32'd0);
    chk("midreset_ovrf", {31'd0, ovrf}, 32'd0);
    chk("midreset_udrf", {31'd0, udrf}, 32'd0);
    exp_q.delete();
    #4 rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("postreset_valid_%0d", i), {31'd0, out_valid}, 32'd0);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
